// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, position type and slew helper
// for the multi-channel servo PWM block.
package servo_pkg;

  localparam int NUM_CH_D   = 2;
  localparam int CLK_HZ_D   = 100_000_000;
  localparam int TICK_HZ_D  = 1_000_000;
  localparam int PERIOD_D   = 3000;
  localparam int MIN_W_D    = 1000;
  localparam int MAX_W_D    = 2000;
  localparam int W_WIDTH_D  = 12;
  localparam int MAX_STEP_D = 50;

  typedef logic [W_WIDTH_D-1:0] width_t;

  // Signed move from act toward pend, limited to +/-step.
  function automatic int clip_step(
    input int pend,
    input int act,
    input int step
  );
    int d;
    d = pend - act;
    if (d > step) return step;
    if (d < -step) return -step;
    return d;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// servo_tick_gen: prescaler giving a 1-cycle tick
// every DIV clocks (high while the count sits at DIV-1).
module servo_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  logic [PW-1:0] r_presc;

  assign o_tick = (r_presc == TOP);

  // Prescaler: count up, wrap on the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (o_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: NUM_CH double-buffered servo PWM outputs.
// Optional SERVO_SLEW_LIMIT_EN limits width change per frame.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_D,
  parameter int CLK_HZ       = CLK_HZ_D,
  parameter int TICK_HZ      = TICK_HZ_D,
  parameter int PERIOD_TICKS = PERIOD_D,
  parameter int MIN_W        = MIN_W_D,
  parameter int MAX_W        = MAX_W_D,
  parameter int W_WIDTH      = W_WIDTH_D,
  parameter int MAX_STEP     = MAX_STEP_D,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [CH_W-1:0]    pos_ch,
  input  logic [W_WIDTH-1:0] pos_data,
  output logic [NUM_CH-1:0]  pwm,
  output logic               frame_start,
  output logic               clamp_err
);

  localparam int SPAN = MAX_W - MIN_W;
  localparam logic [W_WIDTH-1:0] SPAN_W = W_WIDTH'(SPAN);
  localparam logic [W_WIDTH-1:0] NEUT = W_WIDTH'(SPAN / 2);
  localparam logic [W_WIDTH-1:0] LAST = W_WIDTH'(PERIOD_TICKS - 1);
  localparam logic [W_WIDTH:0] MIN_X = (W_WIDTH+1)'(MIN_W);
  localparam logic [CH_W:0] NCH_C = (CH_W+1)'(NUM_CH);

  if ((MAX_W >= PERIOD_TICKS) || (MIN_W >= MAX_W) ||
      (CLK_HZ % TICK_HZ != 0) ||
      (PERIOD_TICKS > 2**W_WIDTH)) begin : g_bad_cfg
    $error("servo_pwm_array: bad parameters");
  end

  logic               w_tick;
  logic               w_last;
  logic               w_bound;
  logic               w_we;
  logic               w_ch_ok;
  logic               w_over;
  logic [W_WIDTH-1:0] w_dat;

  logic [W_WIDTH-1:0] r_cnt;
  logic               r_ready;
  logic               r_fs;
  logic               r_clamp;

  servo_tick_gen #(
    .DIV (CLK_HZ / TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_last  = (r_cnt == LAST);
  assign w_bound = w_tick & w_last;
  assign w_we    = pos_valid & r_ready;
  assign w_ch_ok = ({1'b0, pos_ch} < NCH_C);
  assign w_over  = (pos_data > SPAN_W);
  assign w_dat   = w_over ? SPAN_W : pos_data;

  assign pos_ready   = r_ready;
  assign frame_start = r_fs;
  assign clamp_err   = r_clamp;

  // Frame counter, frame strobe, handshake and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_fs    <= 1'b0;
      r_clamp <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_fs    <= w_bound;
      r_clamp <= w_we & (~w_ch_ok | w_over);
      if (w_tick) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [W_WIDTH-1:0] r_pend;
    logic [W_WIDTH-1:0] r_act;
    logic               r_pwm;
    logic [W_WIDTH:0]   w_lim;

    assign w_lim  = {1'b0, r_act} + MIN_X;
    assign pwm[g] = r_pwm;

    // Pending write, boundary shadow copy and pulse compare.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pend <= NEUT;
        r_act  <= NEUT;
        r_pwm  <= 1'b0;
      end else begin
        if (w_we && w_ch_ok && (pos_ch == CH_W'(g))) begin
          r_pend <= w_dat;
        end
        if (w_bound) begin
`ifdef SERVO_SLEW_LIMIT_EN
          r_act <= W_WIDTH'(int'(r_act) +
                   clip_step(int'(r_pend), int'(r_act), MAX_STEP));
`else
          r_act <= r_pend;
`endif
        end
        r_pwm <= ({1'b0, r_cnt} < w_lim);
      end
    end
  end

endmodule
